r4_butterfly_seq: RTL and testbench

- Sequences one shared single-precision floating add/sub unit through the 16 real operations of a twiddle-free radix-4 butterfly.
- Sits between the 16-point FFT stage controller and the shared adder instance.
- Latches four complex inputs on start, issues one adder operation per slot, and stores intermediate and final results.
- Presents four complex outputs with a one-cycle done pulse.

---
 rtl/r4_butterfly_seq_if.sv | 25 ++
 rtl/r4_butterfly_seq.sv | 87 ++++++++
 tb/tb_r4_butterfly_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/r4_butterfly_seq_if.sv
// r4_butterfly_seq_if: bundles the butterfly control/data bus and the shared-adder bus
//   start    - request a butterfly (sampled in IDLE)
//   in_data  - four complex inputs a..d, 64 bits each, {re,im}
//   busy     - butterfly in progress
//   done     - one-cycle pulse, out_data valid from this cycle
//   out_data - X0..X3, same packing as in_data
//   add_a/add_b/add_ctrl/add_en - adder operands, 0=add 1=sub, enable
//   add_ans  - adder result
// master = stage controller plus adder side, slave = sequencer.
interface r4_butterfly_seq_if;
    logic         start;
    logic [255:0] in_data;
    logic         busy;
    logic         done;
    logic [255:0] out_data;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_ctrl;
    logic         add_en;
    logic [31:0]  add_ans;
    modport master (output start, in_data, add_ans,
                    input  busy, done, out_data, add_a, add_b, add_ctrl, add_en);
    modport slave  (input  start, in_data, add_ans,
                    output busy, done, out_data, add_a, add_b, add_ctrl, add_en);
endinterface

// File: rtl/r4_butterfly_seq.sv
// r4_butterfly_seq: steps one shared FP add/sub unit through the 16 ops of a twiddle-free radix-4 butterfly
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of r4_butterfly_seq_if (start/in_data/busy/done/out_data and the adder bus)
//   ADDER_LAT - register stages in the adder path (0..3); each op lasts ADDER_LAT+1 cycles
module r4_butterfly_seq #(
    parameter int unsigned ADDER_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    r4_butterfly_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam logic [1:0] LAT = 2'(ADDER_LAT);
    state_t       state_q;
    logic [3:0]   op_q;
    logic [1:0]   wait_q;
    logic         busy_q;
    logic         done_q;
    logic [255:0] out_q;
    // Word file: 0..7 = ar,ai,br,bi,cr,ci,dr,di; 8..15 = t0r,t0i,t1r,t1i,t2r,t2i,t3r,t3i.
    // a..d are dead after op 7, so ops 8..15 park X0,X1,X2,X3 in the a,b,c,d slots.
    logic [31:0]  w_q [16];
    logic         run;
    logic [3:0]   src_a;
    logic [3:0]   src_b;
    logic [3:0]   dst;
    logic         sub;
    // Schedule decoded from op bits: op<8 pairs a/c or b/d into t0..t3,
    // op 8..11 combine t0/t2 into X0/X2, op 12..15 combine t1 with swapped t3 into X1/X3.
    always_comb begin
        run   = (state_q == RUN);
        src_a = {op_q[3], 1'b0, op_q[2], op_q[0]};
        src_b = {op_q[3], 1'b1, op_q[2], op_q[0] ^ (op_q[3] & op_q[2])};
        dst   = op_q[3] ? {1'b0, op_q[1], op_q[2], op_q[0]} : {1'b1, op_q[2], op_q[1], op_q[0]};
        sub   = op_q[1] ^ (op_q[3] & op_q[2] & op_q[0]);
    end
    assign bus.add_en   = run;
    assign bus.add_a    = run ? w_q[src_a] : 32'd0;
    assign bus.add_b    = run ? w_q[src_b] : 32'd0;
    assign bus.add_ctrl = run & sub;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out_data = out_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            wait_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    for (int k = 0; k < 4; k++) begin
                        w_q[2*k]   <= bus.in_data[64*k+32 +: 32];
                        w_q[2*k+1] <= bus.in_data[64*k +: 32];
                    end
                    busy_q  <= 1'b1;
                    op_q    <= 4'd0;
                    wait_q  <= 2'd0;
                    state_q <= RUN;
                end
                RUN: if (wait_q == LAT) begin
                    w_q[dst] <= bus.add_ans;
                    wait_q   <= 2'd0;
                    // op 15 finishes the butterfly; the counter never wraps into a new op
                    if (op_q == 4'd15) state_q <= FIN;
                    else op_q <= op_q + 4'd1;
                end else begin
                    wait_q <= wait_q + 2'd1;
                end
                FIN: begin
                    out_q   <= {w_q[6], w_q[7], w_q[4], w_q[5], w_q[2], w_q[3], w_q[0], w_q[1]};
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    op_q    <= 4'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_r4_butterfly_seq.sv
// tb_r4_butterfly_seq: scoreboard bench for r4_butterfly_seq with ADDER_LAT=0 and ADDER_LAT=2 instances
module tb_r4_butterfly_seq;
    logic clk = 1'b0;
    logic rst0_n;
    logic rst2_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   e0;
    typedef struct {
        logic [255:0] data;
        int           at;
    } exp_t;
    exp_t q0[$];
    exp_t q2[$];
    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] THR  = 32'h40400000;
    localparam logic [31:0] FOUR = 32'h40800000;
    localparam logic [31:0] TEN  = 32'h41200000;
    localparam logic [31:0] M2   = 32'hC0000000;
    logic [255:0] ramp_in, ramp_out, eq_in, eq_out;
    logic [15:0]  ctrl_exp;
    logic [31:0]  s1, s2;

    r4_butterfly_seq_if if0 ();
    r4_butterfly_seq_if if2 ();

    r4_butterfly_seq #(.ADDER_LAT(0)) u0 (.clk(clk), .rst_n(rst0_n), .bus(if0.slave));
    r4_butterfly_seq #(.ADDER_LAT(2)) u2 (.clk(clk), .rst_n(rst2_n), .bus(if2.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder model for normal numbers and zero: widen to double, use real arithmetic, narrow back.
    function automatic real f2r(input logic [31:0] f);
        if (f[30:0] == 31'd0) return 0.0;
        return $bitstoreal({f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0});
    endfunction
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] ex;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        ex = d[62:52] - 11'd896;
        return {d[63], ex[7:0], d[51:29]};
    endfunction
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
        return r2f(s ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction
    function automatic logic [255:0] cx4(input logic [31:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i);
        return {x3r, x3i, x2r, x2i, x1r, x1i, x0r, x0i};
    endfunction

    always_comb if0.add_ans = fadd(if0.add_a, if0.add_b, if0.add_ctrl);
    always @(posedge clk) begin
        s1 <= fadd(if2.add_a, if2.add_b, if2.add_ctrl);
        s2 <= s1;
    end
    assign if2.add_ans = s2;

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a done pulse appears.
    always @(negedge clk) begin
        exp_t e;
        if (if0.done) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done0_unexpected actual=done at cyc %0d required=no done", cyc);
            end else begin
                e = q0.pop_front();
                chk("out0", if0.out_data, e.data);
                chk("done0_cyc", 256'(cyc), 256'(e.at));
            end
        end
        if (if2.done) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done2_unexpected actual=done at cyc %0d required=no done", cyc);
            end else begin
                e = q2.pop_front();
                chk("out2", if2.out_data, e.data);
                chk("done2_cyc", 256'(cyc), 256'(e.at));
            end
        end
    end

    task automatic go0(input logic [255:0] d, input logic [255:0] r);
        @(negedge clk);
        if0.in_data = d;
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        q0.push_back(exp_t'{data: r, at: e0 + 17});
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        while (!(sel ? if2.done : if0.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL done_timeout sel=%0d actual=no done after %0d cycles required=done", sel, n);
        end
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] f;
        ramp_in  = cx4(ONE, 0, TWO, 0, THR, 0, FOUR, 0);
        ramp_out = cx4(TEN, 0, M2, TWO, M2, 0, M2, M2);
        eq_in    = cx4(ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE);
        eq_out   = cx4(FOUR, FOUR, 0, 0, 0, 0, 0, 0);
        ctrl_exp = 16'b0110_1100_1100_1100;
        if0.start = 1'b0;
        if0.in_data = '0;
        if2.start = 1'b0;
        if2.in_data = '0;
        rst0_n = 1'b0;
        rst2_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 256'({if0.busy, if0.done, if0.add_en, if0.add_ctrl, if0.add_a, if0.add_b}), '0);
        chk("rst_out", if0.out_data, '0);
        rst0_n = 1'b1;
        rst2_n = 1'b1;
        // ramp, ADDER_LAT=0
        go0(ramp_in, ramp_out);
        chk("busy_run", 256'(if0.busy), 256'(1));
        wait_done(0);
        // equal inputs and the add/sub sequence
        go0(eq_in, eq_out);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ctrl_op%0d", i), 256'(if0.add_ctrl), 256'(ctrl_exp[i]));
            @(negedge clk);
        end
        wait_done(0);
        // start pulses and in_data changes while busy are ignored
        go0(ramp_in, ramp_out);
        repeat (7) @(negedge clk);
        if0.start = 1'b1;
        if0.in_data = eq_in;
        @(negedge clk);
        if0.start = 1'b0;
        wait_until(e0 + 16);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_retrigger", 256'(if0.busy), 256'(0));
        // back-to-back with start held high
        @(negedge clk);
        if0.in_data = ramp_in;
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        q0.push_back(exp_t'{data: ramp_out, at: e0 + 17});
        q0.push_back(exp_t'{data: eq_out, at: e0 + 35});
        @(negedge clk);
        if0.in_data = eq_in;
        wait_until(e0 + 18);
        if0.start = 1'b0;
        chk("busy_b2b", 256'(if0.busy), 256'(1));
        wait_until(e0 + 30);
        chk("hold_out", if0.out_data, ramp_out);
        wait_done(0);
        // async reset at op 10 aborts, then a clean run
        go0(ramp_in, ramp_out);
        void'(q0.pop_back());
        repeat (10) @(negedge clk);
        #1 rst0_n = 1'b0;
        #1;
        chk("arst_state", 256'({if0.busy, if0.done, if0.add_en}), '0);
        chk("arst_out", if0.out_data, '0);
        @(negedge clk);
        rst0_n = 1'b1;
        go0(eq_in, eq_out);
        wait_done(0);
        // ADDER_LAT=2 with the two-stage adder model
        @(negedge clk);
        if2.in_data = ramp_in;
        if2.start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        q2.push_back(exp_t'{data: ramp_out, at: e0 + 49});
        @(negedge clk);
        if2.start = 1'b0;
        if2.in_data = eq_in;
        chk("l2_op0_a", 256'(if2.add_a), 256'(ONE));
        chk("l2_op0_b", 256'(if2.add_b), 256'(THR));
        for (int op = 0; op < 16; op++) begin
            f = {if2.add_a, if2.add_b, if2.add_ctrl};
            repeat (2) begin
                @(negedge clk);
                chk($sformatf("l2_stable_op%0d", op), 256'({if2.add_a, if2.add_b, if2.add_ctrl}), 256'(f));
            end
            @(negedge clk);
        end
        wait_done(1);
        repeat (3) @(negedge clk);
        chk("queues_empty", 256'(q0.size() + q2.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
